// File: rtl/mem_ld_unit.sv
// Load unit: accepts one load request, issues one or two word-aligned reads,
// then aligns and extends the selected byte, half or word for writeback.
module mem_ld_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [29:0] base_q;
    logic        split_q;
    logic [31:0] word0_q;
    logic        accept;

    function automatic logic is_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // A load crosses into the next word only when its last byte lands past byte 3.
    function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
        if (!SPLIT_EN) return 1'b0;
        return ((f3 == F3_LW) && (off != 2'd0)) ||
               (((f3 == F3_LH) || (f3 == F3_LHU)) && (off == 2'd3));
    endfunction

    // hi == lo gives a circular rotate within one word.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0]        cat;
        logic [31:0]        r;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        cat = {hi, lo} >> {off, 3'b000};
        r   = cat[31:0];
        b   = r[7:0];
        h   = r[15:0];
        case (f3)
            F3_LB:   s = 32'(b);
            F3_LH:   s = 32'(h);
            F3_LBU:  s = {24'd0, r[7:0]};
            F3_LHU:  s = {16'd0, r[15:0]};
            default: s = r;
        endcase
        return s;
    endfunction

    assign accept = req_valid && (state == IDLE);

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = 32'd0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = is_legal(req_funct3) ? REQ0 : DONE;
            end
            REQ0: begin
                mem_req  = 1'b1;
                mem_addr = {base_q, 2'b00};
                if (mem_gnt) state_nxt = WAIT0;
            end
            WAIT0: if (mem_rvalid) state_nxt = split_q ? REQ1 : DONE;
            REQ1: begin
                mem_req  = 1'b1;
                mem_addr = {base_q + 30'd1, 2'b00};
                if (mem_gnt) state_nxt = WAIT1;
            end
            WAIT1: if (mem_rvalid) state_nxt = DONE;
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, first-word capture and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            base_q    <= 30'd0;
            split_q   <= 1'b0;
            word0_q   <= 32'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3;
                off_q    <= req_addr[1:0];
                base_q   <= req_addr[31:2];
                split_q  <= needs_split(req_funct3, req_addr[1:0]);
                resp_err <= !is_legal(req_funct3);
                if (!is_legal(req_funct3)) resp_data <= 32'd0;
            end
            if ((state == WAIT0) && mem_rvalid) begin
                word0_q <= mem_rdata;
                if (!split_q) resp_data <= extract(funct3_q, off_q, mem_rdata, mem_rdata);
            end
            if ((state == WAIT1) && mem_rvalid)
                resp_data <= extract(funct3_q, off_q, mem_rdata, word0_q);
        end
    end

endmodule

// File: tb/tb_mem_ld_unit.sv
// Directed bench for mem_ld_unit: one instance with split reads, one without.
module tb_mem_ld_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid_a, req_ready_a, mem_req_a, mem_gnt_a, mem_rvalid_a;
    logic        resp_valid_a, resp_ready_a, resp_err_a;
    logic [2:0]  req_funct3_a;
    logic [31:0] req_addr_a, mem_addr_a, mem_rdata_a, resp_data_a;
    logic        req_valid_b, req_ready_b, mem_req_b, mem_gnt_b, mem_rvalid_b;
    logic        resp_valid_b, resp_ready_b, resp_err_b;
    logic [2:0]  req_funct3_b;
    logic [31:0] req_addr_b, mem_addr_b, mem_rdata_b, resp_data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    mem_ld_unit #(.SPLIT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_funct3(req_funct3_a), .req_addr(req_addr_a),
        .mem_req(mem_req_a), .mem_gnt(mem_gnt_a), .mem_addr(mem_addr_a),
        .mem_rvalid(mem_rvalid_a), .mem_rdata(mem_rdata_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_data(resp_data_a), .resp_err(resp_err_a)
    );

    mem_ld_unit #(.SPLIT_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_funct3(req_funct3_b), .req_addr(req_addr_b),
        .mem_req(mem_req_b), .mem_gnt(mem_gnt_b), .mem_addr(mem_addr_b),
        .mem_rvalid(mem_rvalid_b), .mem_rdata(mem_rdata_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_data(resp_data_b), .resp_err(resp_err_b)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Drives one load on dut_a with optional grant delay and response back-pressure.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] w0, input logic [31:0] w1, input bit split,
                            input int gdly, input int rdly, input logic [31:0] exp,
                            input string name);
        logic [31:0] a0, a1;
        int          lat;
        a0  = {addr[31:2], 2'b00};
        a1  = a0 + 32'd4;
        lat = (split ? 5 : 3) + gdly;
        cyc = 0;
        n_tests++;
        if (req_ready_a !== 1'b1) begin
            n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, req_ready_a);
        end
        req_valid_a = 1'b1; req_funct3_a = f3; req_addr_a = addr;
        step();
        req_valid_a = 1'b0;
        for (int g = 0; g <= gdly; g++) begin
            n_tests++;
            if (mem_req_a !== 1'b1 || mem_addr_a !== a0) begin
                n_fail++;
                $display("FAIL %s req0[%0d]: mem_req=%b addr=%h want 1/%h", name, g, mem_req_a, mem_addr_a, a0);
            end
            mem_gnt_a = (g == gdly);
            step();
        end
        mem_gnt_a = 1'b0;
        mem_rvalid_a = 1'b1; mem_rdata_a = w0;
        step();
        mem_rvalid_a = 1'b0; mem_rdata_a = 32'hBAD0BAD0;
        if (split) begin
            n_tests++;
            if (mem_req_a !== 1'b1 || mem_addr_a !== a1) begin
                n_fail++;
                $display("FAIL %s req1: mem_req=%b addr=%h want 1/%h", name, mem_req_a, mem_addr_a, a1);
            end
            mem_gnt_a = 1'b1;
            step();
            mem_gnt_a = 1'b0;
            mem_rvalid_a = 1'b1; mem_rdata_a = w1;
            step();
            mem_rvalid_a = 1'b0; mem_rdata_a = 32'hBAD0BAD0;
        end
        n_tests++;
        if (resp_valid_a !== 1'b1 || cyc != lat || mem_req_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s latency: resp_valid=%b mem_req=%b cycle=%0d want 1/0/%0d", name, resp_valid_a, mem_req_a, cyc, lat);
        end
        for (int r = 0; r <= rdly; r++) begin
            n_tests++;
            if (resp_valid_a !== 1'b1 || resp_data_a !== exp || resp_err_a !== 1'b0) begin
                n_fail++;
                $display("FAIL %s resp[%0d]: valid=%b data=%h err=%b want 1/%h/0", name, r, resp_valid_a, resp_data_a, resp_err_a, exp);
            end
            resp_ready_a = (r == rdly);
            step();
        end
        resp_ready_a = 1'b0;
        n_tests++;
        if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: resp_valid=%b req_ready=%b want 0/1", name, resp_valid_a, req_ready_a);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (req_ready_a !== 1'b1 || mem_req_a !== 1'b0 || mem_addr_a !== 32'd0 ||
            resp_valid_a !== 1'b0 || resp_data_a !== 32'd0 || resp_err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: rdy=%b mreq=%b maddr=%h rv=%b rd=%h err=%b want 1/0/0/0/0/0",
                     req_ready_a, mem_req_a, mem_addr_a, resp_valid_a, resp_data_a, resp_err_a);
        end
        n_tests++;
        if (req_ready_b !== 1'b1 || mem_req_b !== 1'b0 || resp_valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: rdy=%b mreq=%b rv=%b want 1/0/0", req_ready_b, mem_req_b, resp_valid_b);
        end
    endtask

    task automatic test_aligned();
        run_load(3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 32'hDEADBEEF, "lw_aligned");
    endtask

    task automatic test_byte_half();
        run_load(3'b000, 32'h203, 32'h80123456, 32'h0, 1'b0, 0, 0, 32'hFFFFFF80, "lb_203");
        run_load(3'b100, 32'h203, 32'h80123456, 32'h0, 1'b0, 0, 0, 32'h00000080, "lbu_203");
        run_load(3'b001, 32'h302, 32'h8001ABCD, 32'h0, 1'b0, 0, 0, 32'hFFFF8001, "lh_302");
        run_load(3'b101, 32'h300, 32'h8001ABCD, 32'h0, 1'b0, 0, 0, 32'h0000ABCD, "lhu_300");
    endtask

    task automatic test_split();
        run_load(3'b010, 32'h401, 32'h44332211, 32'h88776655, 1'b1, 0, 0, 32'h55443322, "lw_split");
        run_load(3'b001, 32'h603, 32'h7F000000, 32'h000000FF, 1'b1, 0, 0, 32'hFFFFFF7F, "lh_split");
    endtask

    task automatic test_no_split();
        cyc = 0;
        req_valid_b = 1'b1; req_funct3_b = 3'b010; req_addr_b = 32'h401;
        step();
        req_valid_b = 1'b0;
        n_tests++;
        if (mem_req_b !== 1'b1 || mem_addr_b !== 32'h400) begin
            n_fail++; $display("FAIL nosplit_req0: mem_req=%b addr=%h want 1/00000400", mem_req_b, mem_addr_b);
        end
        mem_gnt_b = 1'b1;
        step();
        mem_gnt_b = 1'b0; mem_rvalid_b = 1'b1; mem_rdata_b = 32'h44332211;
        step();
        mem_rvalid_b = 1'b0; mem_rdata_b = 32'hBAD0BAD0;
        n_tests++;
        if (resp_valid_b !== 1'b1 || resp_data_b !== 32'h11443322 || mem_req_b !== 1'b0 || cyc != 3) begin
            n_fail++;
            $display("FAIL nosplit_resp: valid=%b data=%h mem_req=%b cycle=%0d want 1/11443322/0/3", resp_valid_b, resp_data_b, mem_req_b, cyc);
        end
        resp_ready_b = 1'b1;
        step();
        resp_ready_b = 1'b0;
        n_tests++;
        if (resp_valid_b !== 1'b0 || req_ready_b !== 1'b1) begin
            n_fail++; $display("FAIL nosplit_release: valid=%b ready=%b want 0/1", resp_valid_b, req_ready_b);
        end
    endtask

    task automatic test_stall();
        run_load(3'b010, 32'h500, 32'h0BADF00D, 32'h0, 1'b0, 3, 4, 32'h0BADF00D, "stall");
    endtask

    task automatic test_illegal();
        logic [2:0] ill [3] = '{3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            req_valid_a = 1'b1; req_funct3_a = ill[i]; req_addr_a = 32'h800;
            step();
            req_valid_a = 1'b0;
            n_tests++;
            if (mem_req_a !== 1'b0 || resp_valid_a !== 1'b1 || resp_err_a !== 1'b1 || resp_data_a !== 32'd0) begin
                n_fail++;
                $display("FAIL illegal_%b: mem_req=%b valid=%b err=%b data=%h want 0/1/1/0", ill[i], mem_req_a, resp_valid_a, resp_err_a, resp_data_a);
            end
            resp_ready_a = 1'b1;
            step();
            resp_ready_a = 1'b0;
            n_tests++;
            if (resp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
                n_fail++; $display("FAIL illegal_release: valid=%b ready=%b want 0/1", resp_valid_a, req_ready_a);
            end
        end
        // a legal load afterwards must clear the error flag
        run_load(3'b010, 32'h900, 32'h12345678, 32'h0, 1'b0, 0, 0, 32'h12345678, "after_illegal");
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 3; i++) begin
            mem_rvalid_a = 1'b1; mem_gnt_a = 1'b1; mem_rdata_a = 32'hFFFFFFFF;
            step();
            n_tests++;
            if (req_ready_a !== 1'b1 || resp_valid_a !== 1'b0 || mem_req_a !== 1'b0 || resp_data_a !== 32'h12345678) begin
                n_fail++;
                $display("FAIL spurious[%0d]: rdy=%b rv=%b mreq=%b data=%h want 1/0/0/12345678", i, req_ready_a, resp_valid_a, mem_req_a, resp_data_a);
            end
        end
        mem_rvalid_a = 1'b0; mem_gnt_a = 1'b0;
    endtask

    task automatic test_reset_abort();
        req_valid_a = 1'b1; req_funct3_a = 3'b010; req_addr_a = 32'h700;
        step();
        req_valid_a = 1'b0; mem_gnt_a = 1'b1;
        step();
        mem_gnt_a = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (req_ready_a !== 1'b1 || mem_req_a !== 1'b0 || resp_valid_a !== 1'b0 ||
            resp_data_a !== 32'd0 || resp_err_a !== 1'b0 || mem_addr_a !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_wait0: rdy=%b mreq=%b rv=%b data=%h err=%b maddr=%h want 1/0/0/0/0/0",
                     req_ready_a, mem_req_a, resp_valid_a, resp_data_a, resp_err_a, mem_addr_a);
        end
        step();
        rst_n = 1'b1;
        step();
        req_valid_a = 1'b1; req_funct3_a = 3'b010; req_addr_a = 32'h704;
        step();
        req_valid_a = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_req_a !== 1'b0 || mem_addr_a !== 32'd0 || req_ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_req0: mreq=%b maddr=%h rdy=%b want 0/0/1", mem_req_a, mem_addr_a, req_ready_a);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        run_load(3'b101, 32'hFFFFFFFF, 32'hAB000000, 32'h000000CD, 1'b1, 0, 0, 32'h0000CDAB, "lhu_wrap");
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid_a = 1'b0; req_funct3_a = 3'd0; req_addr_a = 32'd0;
        mem_gnt_a = 1'b0; mem_rvalid_a = 1'b0; mem_rdata_a = 32'd0; resp_ready_a = 1'b0;
        req_valid_b = 1'b0; req_funct3_b = 3'd0; req_addr_b = 32'd0;
        mem_gnt_b = 1'b0; mem_rvalid_b = 1'b0; mem_rdata_b = 32'd0; resp_ready_b = 1'b0;
        cyc = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_aligned();
        test_byte_half();
        test_split();
        test_no_split();
        test_stall();
        test_illegal();
        test_spurious();
        test_reset_abort();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
